// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath,
// memory handshake and ALU control unit (slave).
interface multicycle_ctrl_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       alu_src_b;
  logic [3:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;
  logic       illegal;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b,
           alu_op, reg_write, mem_to_reg, illegal, halted, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b,
           alu_op, reg_write, mem_to_reg, illegal, halted, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with
// datapath enables decoded from the state register and the latched opcode.
module multicycle_ctrl (
  input  logic               clk_i,
  input  logic               reset_i,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_LOAD, OP_STORE, OP_ADDI, OP_BEQ, OP_HALT: is_legal = 1'b1;
      default:                                               is_legal = 1'b0;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;

  logic       mem_req_s, mem_we_s, ir_write_s, pc_write_s, pc_src_s;
  logic       alu_src_b_s, reg_write_s, mem_to_reg_s, illegal_s, halted_s;
  logic [3:0] alu_op_s;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      op_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        op_d = bus.opcode;
        if (bus.opcode == OP_HALT)     state_d = S_HALT;
        else if (!is_legal(bus.opcode)) state_d = S_FETCH;
        else                            state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!bus.mem_ready)      state_d = S_MEM;
        else if (op_q == OP_LOAD) state_d = S_WB;
        else                      state_d = S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // While reset is held every output shows the idle FETCH values, so no
  // write strobe can follow a same-cycle mem_ready or zero.
  always_comb begin
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    alu_src_b_s  = 1'b0;
    alu_op_s     = 4'b0000;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    illegal_s    = 1'b0;
    halted_s     = 1'b0;
    if (reset_i) begin
      mem_req_s = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req_s  = 1'b1;
          ir_write_s = bus.mem_ready;
          pc_write_s = bus.mem_ready;
        end
        S_DECODE: illegal_s = ~is_legal(bus.opcode);
        S_EXEC: begin
          case (op_q)
            OP_RTYPE: alu_op_s = 4'b1111;
            OP_LOAD, OP_STORE, OP_ADDI: begin
              alu_op_s    = 4'b0000;
              alu_src_b_s = 1'b1;
            end
            OP_BEQ: begin
              alu_op_s   = 4'b0001;
              pc_write_s = bus.zero;
              pc_src_s   = 1'b1;
            end
            default: alu_op_s = 4'b0000;
          endcase
        end
        S_MEM: begin
          mem_req_s   = 1'b1;
          mem_we_s    = (op_q == OP_STORE);
          alu_src_b_s = 1'b1;
        end
        S_WB: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = (op_q == OP_LOAD);
        end
        S_HALT:  halted_s = 1'b1;
        default: halted_s = 1'b0;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.pc_write   = pc_write_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.illegal    = illegal_s;
  assign bus.halted     = halted_s;
  assign bus.state      = reset_i ? 3'd0 : state_q;

endmodule
